gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor_if.sv | 32 +++
 rtl/gshare_predictor.sv | 141 ++++++++++++++
 tb/tb_gshare_predictor.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the gshare branch predictor.
// The predictor takes the slave side; the pipeline drives it as master.
interface gshare_predictor_if #(
    parameter int HIST_BITS = 12
);
    logic [31:0]          Instr_input;
    logic [31:0]          Instr_addr_input;
    logic                 Update_valid;
    logic                 Update_taken;
    logic [HIST_BITS-1:0] Update_index;
    logic [HIST_BITS-1:0] Update_hist;
    logic                 Update_mispredict;
    logic                 Taken;
    logic                 Is_branch;
    logic [HIST_BITS-1:0] Pred_index;
    logic [HIST_BITS-1:0] Pred_hist;
    logic                 Ready;

    modport master (
        output Instr_input, Instr_addr_input,
        output Update_valid, Update_taken, Update_index,
        output Update_hist, Update_mispredict,
        input  Taken, Is_branch, Pred_index, Pred_hist, Ready
    );

    modport slave (
        input  Instr_input, Instr_addr_input,
        input  Update_valid, Update_taken, Update_index,
        input  Update_hist, Update_mispredict,
        output Taken, Is_branch, Pred_index, Pred_hist, Ready
    );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: GHR-indexed PHT of saturating counters,
// speculative history shift with checkpoint restore on mispredict.
module gshare_predictor #(
    parameter int HIST_BITS = 12,
    parameter int CTR_BITS  = 2,
    parameter int USE_XOR   = 1
) (
    input  logic CLK,
    input  logic RESET,
    gshare_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << HIST_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT =
        CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [HIST_BITS-1:0] IDX_LAST = '1;
    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [HIST_BITS-1:0] init_cnt_q, init_cnt_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic [HIST_BITS-1:0] pred_index_q, pred_index_d;
    logic [HIST_BITS-1:0] pred_hist_q, pred_hist_d;
    logic                 taken_q, taken_d;
    logic                 is_branch_q, is_branch_d;
    logic                 ready_q, ready_d;
    logic [CTR_BITS-1:0]  pht_q [ENTRIES];

    logic [5:0]           opcode;
    logic [4:0]           rt;
    logic                 is_br;
    logic                 pred_bit;
    logic [HIST_BITS-1:0] idx;
    logic [HIST_BITS-1:0] ui;
    logic                 unused_ok;

    assign opcode = bp.Instr_input[31:26];
    assign rt     = bp.Instr_input[20:16];
    assign ui     = bp.Update_index;

    // REGIMM branches are selected by rt; 000100..000111 are BEQ/BNE/BLEZ/BGTZ
    always_comb begin
        is_br = 1'b0;
        unique case (opcode)
            6'b000001: is_br = (rt == 5'b00000) || (rt == 5'b00001) ||
                               (rt == 5'b10000) || (rt == 5'b10001);
            6'b000100, 6'b000101,
            6'b000110, 6'b000111: is_br = 1'b1;
            default: is_br = 1'b0;
        endcase
    end

    if (USE_XOR != 0) begin : g_xor
        assign idx = ghr_q ^ bp.Instr_addr_input[HIST_BITS+1:2];
    end else begin : g_glob
        assign idx = ghr_q;
    end

    assign pred_bit = is_br & pht_q[idx][CTR_BITS-1];

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        ghr_d        = ghr_q;
        taken_d      = 1'b0;
        is_branch_d  = 1'b0;
        pred_index_d = '0;
        pred_hist_d  = '0;
        ready_d      = ready_q;
        unique case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + HIST_BITS'(1);
                ghr_d      = '0;
                if (init_cnt_q == IDX_LAST) begin
                    state_d = S_READY;
                    ready_d = 1'b1;
                end
            end
            S_READY: begin
                taken_d      = pred_bit;
                is_branch_d  = is_br;
                pred_index_d = idx;
                pred_hist_d  = ghr_q;
                // A mispredict restore wins over the speculative shift
                if (bp.Update_valid && bp.Update_mispredict)
                    ghr_d = {bp.Update_hist[HIST_BITS-2:0],
                             bp.Update_taken};
                else if (is_br)
                    ghr_d = {ghr_q[HIST_BITS-2:0], pred_bit};
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= S_INIT;
            init_cnt_q   <= '0;
            ghr_q        <= '0;
            taken_q      <= 1'b0;
            is_branch_q  <= 1'b0;
            pred_index_q <= '0;
            pred_hist_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            ghr_q        <= ghr_d;
            taken_q      <= taken_d;
            is_branch_q  <= is_branch_d;
            pred_index_q <= pred_index_d;
            pred_hist_q  <= pred_hist_d;
            ready_q      <= ready_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (state_q == S_INIT) begin
                pht_q[init_cnt_q] <= CTR_INIT;
            end else if (bp.Update_valid) begin
                if (bp.Update_taken) begin
                    if (pht_q[ui] != CTR_MAX)
                        pht_q[ui] <= pht_q[ui] + CTR_BITS'(1);
                end else if (pht_q[ui] != '0) begin
                    pht_q[ui] <= pht_q[ui] - CTR_BITS'(1);
                end
            end
        end
    end

    assign bp.Taken      = taken_q;
    assign bp.Is_branch  = is_branch_q;
    assign bp.Pred_index = pred_index_q;
    assign bp.Pred_hist  = pred_hist_q;
    assign bp.Ready      = ready_q;

    assign unused_ok = ^{bp.Instr_input[25:21], bp.Instr_input[15:0],
                         bp.Instr_addr_input, bp.Update_hist[HIST_BITS-1]};
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed and randomized checks of gshare_predictor, two instances
// (pure global index and gshare index) sharing one stimulus stream.
module tb_gshare_predictor;
    localparam int HB = 4;

    logic          clk;
    logic          rst_n;
    logic [31:0]   instr;
    logic [31:0]   addr;
    logic          uv;
    logic          ut;
    logic [HB-1:0] ui;
    logic [HB-1:0] uh;
    logic          mis;

    int n_tests = 0;
    int n_fail  = 0;

    int mpht [2][16];
    int mghr [2];

    gshare_predictor_if #(.HIST_BITS(HB)) bp0 ();
    gshare_predictor_if #(.HIST_BITS(HB)) bp1 ();

    assign bp0.Instr_input       = instr;
    assign bp0.Instr_addr_input  = addr;
    assign bp0.Update_valid      = uv;
    assign bp0.Update_taken      = ut;
    assign bp0.Update_index      = ui;
    assign bp0.Update_hist       = uh;
    assign bp0.Update_mispredict = mis;
    assign bp1.Instr_input       = instr;
    assign bp1.Instr_addr_input  = addr;
    assign bp1.Update_valid      = uv;
    assign bp1.Update_taken      = ut;
    assign bp1.Update_index      = ui;
    assign bp1.Update_hist       = uh;
    assign bp1.Update_mispredict = mis;

    gshare_predictor #(.HIST_BITS(HB), .CTR_BITS(2), .USE_XOR(0)) u_glob (
        .CLK   (clk),
        .RESET (rst_n),
        .bp    (bp0)
    );

    gshare_predictor #(.HIST_BITS(HB), .CTR_BITS(2), .USE_XOR(1)) u_xor (
        .CLK   (clk),
        .RESET (rst_n),
        .bp    (bp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic v, input logic t, input int i,
                       input int h, input logic m);
        uv  = v;
        ut  = t;
        ui  = HB'(i);
        uh  = HB'(h);
        mis = m;
    endtask

    // Count Ready-high cycles while initialisation must still be running
    task automatic wait_init(input string tag);
        int early;
        early = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (bp0.Ready !== 1'b0 || bp1.Ready !== 1'b0) early++;
        end
        chk({tag, "_early_ready"}, early, 0);
        tick();
        chk({tag, "_ready0"}, bp0.Ready, 1);
        chk({tag, "_ready1"}, bp1.Ready, 1);
    endtask

    function automatic bit m_isbr(input logic [31:0] w);
        int unsigned op;
        int unsigned rt;
        op = int'(w) >>> 0;
        op = w[31:26];
        rt = w[20:16];
        if (op == 1)
            return (rt == 0) || (rt == 1) || (rt == 16) || (rt == 17);
        return (op >= 4) && (op <= 7);
    endfunction

    initial begin
        int r;
        int idx;
        bit br;
        bit et [2];
        int ei [2];
        int eh [2];

        rst_n = 1'b0;
        instr = 32'h0;
        addr  = 32'h0;
        upd(0, 0, 0, 0, 0);

        tick();
        tick();
        chk("rst_taken", bp0.Taken, 0);
        chk("rst_isbr", bp0.Is_branch, 0);
        chk("rst_pidx", bp1.Pred_index, 0);
        chk("rst_phist", bp1.Pred_hist, 0);
        chk("rst_ready", bp0.Ready, 0);

        rst_n = 1'b1;
        wait_init("init");

        // Fresh PHT is weakly not-taken
        instr = 32'h1000_0000;
        tick();
        chk("beq_fresh_taken", bp0.Taken, 0);
        chk("beq_fresh_isbr", bp0.Is_branch, 1);
        chk("beq_fresh_hist", bp0.Pred_hist, 0);

        // Train index 5 up twice, predict via gshare index 0^5
        instr = 32'h0;
        upd(1, 1, 5, 0, 0);
        tick();
        tick();
        upd(0, 0, 0, 0, 0);
        instr = 32'h1000_0000;
        addr  = 32'h14;
        tick();
        chk("train_up_taken", bp1.Taken, 1);
        chk("train_up_pidx", bp1.Pred_index, 5);
        instr = 32'h0;
        addr  = 32'h0;
        upd(1, 0, 5, 0, 1);
        tick();
        upd(1, 0, 5, 0, 0);
        tick();
        tick();
        upd(0, 0, 0, 0, 0);
        instr = 32'h1000_0000;
        addr  = 32'h14;
        tick();
        chk("train_dn_taken", bp1.Taken, 0);
        chk("train_dn_hist", bp1.Pred_hist, 0);

        // History restore after a mispredicted BNE
        instr = 32'h1400_0000;
        addr  = 32'h0;
        tick();
        chk("bne_taken", bp0.Taken, 0);
        chk("bne_pidx", bp0.Pred_index, 0);
        instr = 32'h0;
        upd(1, 1, 0, 0, 1);
        tick();
        upd(0, 0, 0, 0, 0);
        instr = 32'h1400_0000;
        tick();
        chk("restore_hist", bp0.Pred_hist, 1);
        chk("restore_pidx", bp0.Pred_index, 1);
        instr = 32'h0;
        upd(1, 0, 1, 0, 1);
        tick();

        // Same-cycle prediction and update on index 2 reads old counter
        upd(1, 1, 2, 0, 0);
        instr = 32'h1000_0000;
        addr  = 32'h8;
        tick();
        chk("collide_taken", bp1.Taken, 0);
        chk("collide_pidx", bp1.Pred_index, 2);
        upd(0, 0, 0, 0, 0);
        tick();
        chk("collide_next", bp1.Taken, 1);
        instr = 32'h0;
        addr  = 32'h0;
        upd(1, 1, 15, 0, 1);
        tick();

        // Decode: non-branches leave GHR (=0001) alone
        upd(0, 0, 0, 0, 0);
        instr = 32'h0402_0000;
        tick();
        chk("regimm_rt2_isbr", bp0.Is_branch, 0);
        chk("regimm_rt2_taken", bp0.Taken, 0);
        instr = 32'h0043_1020;
        tick();
        chk("add_isbr", bp0.Is_branch, 0);
        chk("add_hist", bp0.Pred_hist, 1);
        instr = 32'h0411_0000;
        tick();
        chk("bgezal_isbr", bp0.Is_branch, 1);
        chk("bgezal_hist", bp0.Pred_hist, 1);

        // Mid-operation reset wipes trained entry 2
        instr = 32'h0;
        upd(1, 0, 4, 0, 1);
        tick();
        upd(0, 0, 0, 0, 0);
        instr = 32'h1000_0000;
        addr  = 32'h8;
        tick();
        chk("pre_rst_taken", bp1.Taken, 1);
        instr = 32'h0;
        addr  = 32'h0;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_taken", bp1.Taken, 0);
        chk("mid_rst_isbr", bp1.Is_branch, 0);
        chk("mid_rst_phist", bp1.Pred_hist, 0);
        chk("mid_rst_ready", bp1.Ready, 0);
        rst_n = 1'b1;
        wait_init("reinit");
        instr = 32'h1000_0000;
        addr  = 32'h8;
        tick();
        chk("post_rst_taken", bp1.Taken, 0);
        chk("post_rst_pidx", bp1.Pred_index, 2);

        // Fresh init, then random traffic against the reference model
        instr = 32'h0;
        addr  = 32'h0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_init("rinit");
        for (int u = 0; u < 2; u++) begin
            mghr[u] = 0;
            for (int e = 0; e < 16; e++) mpht[u][e] = 1;
        end

        for (int c = 0; c < 600; c++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0)
                instr = {3'b000, 1'b1, $urandom_range(0, 3) == 0 ? 2'b00 :
                         2'($urandom_range(0, 3)), 26'($urandom)};
            else if (r == 1)
                instr = {6'b000001, 5'($urandom), 5'($urandom_range(0, 31)),
                         16'($urandom)};
            else
                instr = $urandom;
            addr = $urandom;
            upd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                $urandom_range(0, 3) == 0);

            br = m_isbr(instr);
            for (int u = 0; u < 2; u++) begin
                idx = mghr[u];
                if (u == 1) idx = mghr[u] ^ (int'(addr >> 2) % 16);
                et[u] = br && (mpht[u][idx] >= 2);
                ei[u] = idx;
                eh[u] = mghr[u];
                if (uv && mis)
                    mghr[u] = (int'(uh) * 2 + int'(ut)) % 16;
                else if (br)
                    mghr[u] = (mghr[u] * 2 + int'(et[u])) % 16;
                if (uv) begin
                    if (ut && mpht[u][ui] < 3) mpht[u][ui] += 1;
                    if (!ut && mpht[u][ui] > 0) mpht[u][ui] -= 1;
                end
            end

            tick();
            chk("rnd_taken0", bp0.Taken, et[0]);
            chk("rnd_isbr0", bp0.Is_branch, br);
            chk("rnd_pidx0", bp0.Pred_index, ei[0]);
            chk("rnd_phist0", bp0.Pred_hist, eh[0]);
            chk("rnd_taken1", bp1.Taken, et[1]);
            chk("rnd_isbr1", bp1.Is_branch, br);
            chk("rnd_pidx1", bp1.Pred_index, ei[1]);
            chk("rnd_phist1", bp1.Pred_hist, eh[1]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
